// File: rtl/seq_alu.sv
// seq_alu: registered ALU with internal Zero/Carry flags, multi-cycle rotate-through-carry
// and shift-add multiply behind a Start/Busy/Done handshake.
// Optional feature: define OVERFLOW_FLAG_EN to add the OvfOut signed-overflow flag.
module seq_alu #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       OP,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    input  logic [SHW-1:0]   ShAmt,
    output logic [WIDTH-1:0] Out,
    output logic [WIDTH-1:0] OutHi,
    output logic             ZeroOut,
    output logic             CarryOut,
`ifdef OVERFLOW_FLAG_EN
    output logic             OvfOut,
`endif
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned W1 = WIDTH + 1;
    localparam int unsigned CW = SHW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_ADDC = 4'h1,
        OP_SUB  = 4'h2,
        OP_SUBC = 4'h3,
        OP_OR   = 4'h4,
        OP_AND  = 4'h5,
        OP_XOR  = 4'h6,
        OP_CMP  = 4'h7,
        OP_MOVB = 4'h8,
        OP_COM  = 4'h9,
        OP_INC  = 4'hA,
        OP_DEC  = 4'hB,
        OP_RLC  = 4'hC,
        OP_RRC  = 4'hD,
        OP_MUL  = 4'hE,
        OP_CLRC = 4'hF
    } op_t;

    state_t               state_q, state_d;
    op_t                  op_q, op_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 rot_c_q, rot_c_d;
    logic [WIDTH-1:0]     mul_b_q, mul_b_d;
    logic [WIDTH-1:0]     mul_lo_q, mul_lo_d;
    logic [WIDTH-1:0]     mul_hi_q, mul_hi_d;
    logic [WIDTH-1:0]     out_d, hi_d;
    logic                 z_d, c_d, busy_d, done_d;
`ifdef OVERFLOW_FLAG_EN
    logic                 ovf_d;
`endif

    logic [W1-1:0]        sum, diff, mul_sum;
    logic [WIDTH-1:0]     rot_l, rot_r;
    logic [2*WIDTH-1:0]   mul_next;

    // Shared arithmetic: add/sub with carry-in, one rotate step, one multiply step.
    always_comb begin
        sum      = W1'(InputA) + W1'(InputB) + W1'((op_t'(OP) == OP_ADDC) && CarryOut);
        diff     = W1'(InputB) - W1'(InputA) - W1'((op_t'(OP) == OP_SUBC) && CarryOut);
        rot_l    = {Out[WIDTH-2:0], rot_c_q};
        rot_r    = {rot_c_q, Out[WIDTH-1:1]};
        mul_sum  = W1'(mul_hi_q) + (mul_lo_q[0] ? W1'(mul_b_q) : W1'(0));
        mul_next = {mul_sum, mul_lo_q[WIDTH-1:1]};
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        rot_c_d  = rot_c_q;
        mul_b_d  = mul_b_q;
        mul_lo_d = mul_lo_q;
        mul_hi_d = mul_hi_q;
        out_d    = Out;
        hi_d     = OutHi;
        z_d      = ZeroOut;
        c_d      = CarryOut;
        busy_d   = 1'b0;
        done_d   = 1'b0;
`ifdef OVERFLOW_FLAG_EN
        ovf_d    = OvfOut;
`endif

        case (state_q)
            IDLE, FINISH: begin
                state_d = IDLE;
                if (Start) begin
                    op_d    = op_t'(OP);
                    state_d = FINISH;
                    done_d  = 1'b1;
                    if (op_t'(OP) != OP_MUL) begin
                        hi_d = '0;
                    end
                    case (op_t'(OP))
                        OP_ADD, OP_ADDC: begin
                            out_d = sum[WIDTH-1:0];
                            c_d   = sum[WIDTH];
                            z_d   = ~|out_d;
`ifdef OVERFLOW_FLAG_EN
                            ovf_d = (InputA[WIDTH-1] == InputB[WIDTH-1]) &&
                                    (sum[WIDTH-1] != InputA[WIDTH-1]);
`endif
                        end
                        OP_SUB, OP_SUBC: begin
                            out_d = diff[WIDTH-1:0];
                            c_d   = diff[WIDTH];
                            z_d   = ~|out_d;
`ifdef OVERFLOW_FLAG_EN
                            ovf_d = (InputA[WIDTH-1] != InputB[WIDTH-1]) &&
                                    (diff[WIDTH-1] != InputB[WIDTH-1]);
`endif
                        end
                        OP_OR: begin
                            out_d = InputA | InputB;
                            z_d   = ~|out_d;
                        end
                        OP_AND: begin
                            out_d = InputA & InputB;
                            z_d   = ~|out_d;
                        end
                        OP_XOR: begin
                            out_d = InputA ^ InputB;
                            z_d   = ~|out_d;
                        end
                        OP_CMP: begin
                            z_d = (InputA == InputB);
                            c_d = (InputB < InputA);
                        end
                        OP_MOVB: begin
                            out_d = InputB;
                            z_d   = ~|out_d;
                        end
                        OP_COM: begin
                            out_d = ~InputB;
                            z_d   = ~|out_d;
                        end
                        OP_INC: begin
                            out_d = InputB + WIDTH'(1);
                            z_d   = ~|out_d;
                        end
                        OP_DEC: begin
                            out_d = InputA - WIDTH'(1);
                            z_d   = ~|out_d;
                        end
                        OP_RLC, OP_RRC: begin
                            // A zero count finishes at once with the flags untouched.
                            out_d = InputA;
                            if (ShAmt != '0) begin
                                state_d = EXEC;
                                done_d  = 1'b0;
                                busy_d  = 1'b1;
                                rot_c_d = CarryOut;
                                cnt_d   = ShAmt - CW'(1);
                            end
                        end
                        OP_MUL: begin
                            state_d  = EXEC;
                            done_d   = 1'b0;
                            busy_d   = 1'b1;
                            mul_lo_d = InputA;
                            mul_b_d  = InputB;
                            mul_hi_d = '0;
                            cnt_d    = CW'(WIDTH - 1);
                        end
                        OP_CLRC: begin
                            c_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            EXEC: begin
                busy_d = 1'b1;
                cnt_d  = cnt_q - CW'(1);
                if (op_q == OP_MUL) begin
                    mul_hi_d = mul_next[2*WIDTH-1:WIDTH];
                    mul_lo_d = mul_next[WIDTH-1:0];
                end else begin
                    rot_c_d = (op_q == OP_RLC) ? Out[WIDTH-1] : Out[0];
                    out_d   = (op_q == OP_RLC) ? rot_l : rot_r;
                end
                // Last step: publish result and flags together.
                if (cnt_q == '0) begin
                    state_d = FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (op_q == OP_MUL) begin
                        out_d = mul_next[WIDTH-1:0];
                        hi_d  = mul_next[2*WIDTH-1:WIDTH];
                        z_d   = ~|mul_next;
                        c_d   = |mul_next[2*WIDTH-1:WIDTH];
                    end else begin
                        c_d = rot_c_d;
                        z_d = ~|out_d;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, flag and handshake registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            op_q     <= OP_ADD;
            cnt_q    <= '0;
            rot_c_q  <= 1'b0;
            mul_b_q  <= '0;
            mul_lo_q <= '0;
            mul_hi_q <= '0;
            Out      <= '0;
            OutHi    <= '0;
            ZeroOut  <= 1'b0;
            CarryOut <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            OvfOut   <= 1'b0;
`endif
        end else begin
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            rot_c_q  <= rot_c_d;
            mul_b_q  <= mul_b_d;
            mul_lo_q <= mul_lo_d;
            mul_hi_q <= mul_hi_d;
            Out      <= out_d;
            OutHi    <= hi_d;
            ZeroOut  <= z_d;
            CarryOut <= c_d;
            Busy     <= busy_d;
            Done     <= done_d;
`ifdef OVERFLOW_FLAG_EN
            OvfOut   <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu (WIDTH=8): directed vector table, hand-written handshake
// sequences, then random operations against an arithmetic reference model.
`timescale 1ns/1ps
module tb_seq_alu;

    localparam int unsigned W   = 8;
    localparam int unsigned SHW = 3;

    logic           Clk;
    logic           Reset;
    logic           Start;
    logic [3:0]     OP;
    logic [W-1:0]   InputA;
    logic [W-1:0]   InputB;
    logic [SHW-1:0] ShAmt;
    logic [W-1:0]   Out;
    logic [W-1:0]   OutHi;
    logic           ZeroOut;
    logic           CarryOut;
    logic           Busy;
    logic           Done;
`ifdef OVERFLOW_FLAG_EN
    logic           OvfOut;
`endif

    seq_alu #(.WIDTH(W), .SHW(SHW)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .OP       (OP),
        .InputA   (InputA),
        .InputB   (InputB),
        .ShAmt    (ShAmt),
        .Out      (Out),
        .OutHi    (OutHi),
        .ZeroOut  (ZeroOut),
        .CarryOut (CarryOut),
`ifdef OVERFLOW_FLAG_EN
        .OvfOut   (OvfOut),
`endif
        .Busy     (Busy),
        .Done     (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_tests;
    int n_fail;

    // Reference model state: architectural result registers and flags.
    longint m_out, m_hi, m_z, m_c, m_ovf;

    typedef struct {
        logic [3:0]     op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [SHW-1:0] sh;
        logic [W-1:0]   out;
        logic [W-1:0]   hi;
        logic           z;
        logic           c;
        logic           ovf;
        int             lat;
        bit             poke;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [SHW-1:0] sh, input logic [W-1:0] out, input logic [W-1:0] hi,
                           input logic z, input logic c, input logic ovf, input int lat, input bit poke);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.sh = sh; v.out = out; v.hi = hi;
        v.z = z; v.c = c; v.ovf = ovf; v.lat = lat; v.poke = poke;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic longint b2l(input bit x);
        return x ? longint'(1) : longint'(0);
    endfunction

    function automatic longint sgn(input longint x);
        return b2l(x >= (longint'(1) << (W - 1)));
    endfunction

    // Behavioural model: apply one operation to the model state, return expected latency.
    task automatic model_apply(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic [SHW-1:0] shv, output int lat);
        longint mm, a, b, r, v, cin;
        int n;
        mm  = longint'(1) << W;
        a   = longint'(av);
        b   = longint'(bv);
        n   = int'(shv);
        lat = 1;
        if (op != 4'hE) m_hi = 0;
        case (op)
            4'h0, 4'h1: begin
                cin   = (op == 4'h1) ? m_c : longint'(0);
                r     = a + b + cin;
                m_out = r % mm;
                m_c   = b2l(r >= mm);
                m_z   = b2l(m_out == 0);
                m_ovf = b2l(sgn(a) == sgn(b) && sgn(m_out) != sgn(a));
            end
            4'h2, 4'h3: begin
                cin   = (op == 4'h3) ? m_c : longint'(0);
                r     = b - a - cin;
                m_c   = b2l(r < 0);
                m_out = (r + mm) % mm;
                m_z   = b2l(m_out == 0);
                m_ovf = b2l(sgn(a) != sgn(b) && sgn(m_out) != sgn(b));
            end
            4'h4: begin m_out = a | b; m_z = b2l(m_out == 0); end
            4'h5: begin m_out = a & b; m_z = b2l(m_out == 0); end
            4'h6: begin m_out = a ^ b; m_z = b2l(m_out == 0); end
            4'h7: begin m_z = b2l(a == b); m_c = b2l(b < a); end
            4'h8: begin m_out = b;                  m_z = b2l(m_out == 0); end
            4'h9: begin m_out = (~b) & (mm - 1);    m_z = b2l(m_out == 0); end
            4'hA: begin m_out = (b + 1) % mm;       m_z = b2l(m_out == 0); end
            4'hB: begin m_out = (a - 1 + mm) % mm;  m_z = b2l(m_out == 0); end
            4'hC, 4'hD: begin
                if (n == 0) begin
                    m_out = a;
                end else begin
                    // Rotate the (W+1)-bit quantity {C, A} by n places.
                    v = m_c * mm + a;
                    if (op == 4'hC) v = ((v << n) | (v >> (W + 1 - n))) & (2 * mm - 1);
                    else            v = ((v >> n) | (v << (W + 1 - n))) & (2 * mm - 1);
                    m_c   = v >> W;
                    m_out = v & (mm - 1);
                    m_z   = b2l(m_out == 0);
                    lat   = n + 1;
                end
            end
            4'hE: begin
                r     = a * b;
                m_out = r % mm;
                m_hi  = r / mm;
                m_z   = b2l(r == 0);
                m_c   = b2l(m_hi != 0);
                lat   = W + 1;
            end
            default: m_c = 0;
        endcase
    endtask

    // Issue one operation and wait (bounded) for Done; optionally fire ignored Starts while busy.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [SHW-1:0] sh, input bit poke,
                          output int lat, output bit busy_ok);
        logic z0, c0;
        bit   done_seen;
        @(negedge Clk);
        check({tag, " idle busy/done"}, 64'({Busy, Done}), 64'(2'b00));
        z0 = ZeroOut;
        c0 = CarryOut;
        Start = 1'b1; OP = op; InputA = a; InputB = b; ShAmt = sh;
        @(negedge Clk);
        Start = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        done_seen = 1'b0;
        for (int k = 1; k <= 64 && !done_seen; k++) begin
            if (k > 1) begin
                @(negedge Clk);
                Start = 1'b0;
            end
            if (Done) begin
                lat = k;
                done_seen = 1'b1;
                if (Busy) busy_ok = 1'b0;
            end else begin
                if (!Busy || ZeroOut !== z0 || CarryOut !== c0) busy_ok = 1'b0;
                if (poke && $urandom_range(1, 0) == 1) begin
                    Start = 1'b1;
                    OP = 4'($urandom);
                    InputA = W'($urandom);
                    InputB = W'($urandom);
                    ShAmt = SHW'($urandom);
                end
            end
        end
    endtask

    task automatic check_model(input string tag, input int lat, input int exp_lat, input bit busy_ok);
        check({tag, " out"},  64'(Out),      m_out);
        check({tag, " hi"},   64'(OutHi),    m_hi);
        check({tag, " z"},    64'(ZeroOut),  m_z);
        check({tag, " c"},    64'(CarryOut), m_c);
        check({tag, " lat"},  64'(lat),      64'(exp_lat));
        check({tag, " busy"}, 64'(busy_ok),  64'(1));
`ifdef OVERFLOW_FLAG_EN
        check({tag, " ovf"},  64'(OvfOut),   m_ovf);
`endif
    endtask

    // Safety net in case the design never answers.
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  lat, exp_lat;
        bit  busy_ok, saw_done;
        logic [3:0]     rop;
        logic [W-1:0]   ra, rb;
        logic [SHW-1:0] rsh;
        vec_t v;

        n_tests = 0;
        n_fail  = 0;
        m_out = 0; m_hi = 0; m_z = 0; m_c = 0; m_ovf = 0;

        //      op     A      B      sh    Out    OutHi  Z     C     V     lat poke
        add_vec(4'h0, 8'hF0, 8'h20, 3'd0, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0, 1, 0); // ADD
        add_vec(4'h1, 8'h00, 8'h00, 3'd0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1, 0); // ADDC
        add_vec(4'h2, 8'h05, 8'h03, 3'd0, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b0, 1, 0); // SUB
        add_vec(4'h3, 8'h00, 8'h00, 3'd0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1, 0); // SUBC
        add_vec(4'hE, 8'hFF, 8'hFF, 3'd0, 8'h01, 8'hFE, 1'b0, 1'b1, 1'b0, 9, 1); // MUL
        add_vec(4'hF, 8'h00, 8'h00, 3'd0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1, 0); // CLRC
        add_vec(4'hC, 8'h81, 8'h00, 3'd1, 8'h02, 8'h00, 1'b0, 1'b1, 1'b0, 2, 0); // RLC 1
        add_vec(4'hF, 8'h00, 8'h00, 3'd0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1, 0); // CLRC
        add_vec(4'hD, 8'h01, 8'h00, 3'd0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1, 0); // RRC 0
        add_vec(4'h6, 8'h5A, 8'h5A, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1, 0); // XOR
        add_vec(4'h7, 8'h12, 8'h34, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1, 0); // CMP ne
        add_vec(4'h7, 8'h77, 8'h77, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1, 0); // CMP eq
        add_vec(4'hA, 8'h00, 8'hFF, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1, 0); // INC wrap
        add_vec(4'hB, 8'h00, 8'h00, 3'd0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1, 0); // DEC wrap
        add_vec(4'h9, 8'h00, 8'hFF, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1, 0); // COM
        add_vec(4'h8, 8'h00, 8'hA5, 3'd0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 1, 0); // MOVB
        add_vec(4'h4, 8'h0F, 8'hF0, 3'd0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1, 0); // OR
        add_vec(4'h5, 8'h0F, 8'hF0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1, 0); // AND
        add_vec(4'h2, 8'h03, 8'h05, 3'd0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1, 0); // SUB
        add_vec(4'hE, 8'h00, 8'h37, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 9, 1); // MUL zero
        add_vec(4'hD, 8'h01, 8'h00, 3'd1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 2, 0); // RRC 1
        add_vec(4'hC, 8'h80, 8'h00, 3'd7, 8'h60, 8'h00, 1'b0, 1'b0, 1'b0, 8, 1); // RLC 7
        add_vec(4'h0, 8'h7F, 8'h01, 3'd0, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1, 0); // ADD ovf
        add_vec(4'h2, 8'h01, 8'h80, 3'd0, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b1, 1, 0); // SUB ovf

        Reset = 1'b0; Start = 1'b0; OP = '0; InputA = '0; InputB = '0; ShAmt = '0;
        repeat (2) @(negedge Clk);
        check("reset out",  64'(Out),      64'(0));
        check("reset hi",   64'(OutHi),    64'(0));
        check("reset z",    64'(ZeroOut),  64'(0));
        check("reset c",    64'(CarryOut), 64'(0));
        check("reset busy", 64'(Busy),     64'(0));
        check("reset done", 64'(Done),     64'(0));
        Reset = 1'b1;

        // Directed table.
        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            v = vecs[i];
            tag = $sformatf("vec%0d", i);
            model_apply(v.op, v.a, v.b, v.sh, exp_lat);
            run_op(tag, v.op, v.a, v.b, v.sh, v.poke, lat, busy_ok);
            check({tag, " out"},  64'(Out),      64'(v.out));
            check({tag, " hi"},   64'(OutHi),    64'(v.hi));
            check({tag, " z"},    64'(ZeroOut),  64'(v.z));
            check({tag, " c"},    64'(CarryOut), 64'(v.c));
            check({tag, " lat"},  64'(lat),      64'(v.lat));
            check({tag, " busy"}, 64'(busy_ok),  64'(1));
`ifdef OVERFLOW_FLAG_EN
            check({tag, " ovf"},  64'(OvfOut),   64'(v.ovf));
`endif
        end

        // Reset in the middle of a multiply: abort, no Done, then a clean rerun.
        @(negedge Clk);
        Start = 1'b1; OP = 4'hE; InputA = 8'hFF; InputB = 8'hFF;
        @(negedge Clk);
        Start = 1'b0;
        repeat (2) @(negedge Clk);
        #2 Reset = 1'b0;
        #1;
        check("abort out",  64'(Out),      64'(0));
        check("abort hi",   64'(OutHi),    64'(0));
        check("abort busy", 64'(Busy),     64'(0));
        check("abort done", 64'(Done),     64'(0));
        check("abort c",    64'(CarryOut), 64'(0));
        @(negedge Clk);
        Reset = 1'b1;
        m_out = 0; m_hi = 0; m_z = 0; m_c = 0; m_ovf = 0;
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge Clk);
            if (Done) saw_done = 1'b1;
        end
        check("abort no done", 64'(saw_done), 64'(0));
        model_apply(4'hE, 8'hFF, 8'hFF, 3'd0, exp_lat);
        run_op("mul after abort", 4'hE, 8'hFF, 8'hFF, 3'd0, 1'b1, lat, busy_ok);
        check_model("mul after abort", lat, exp_lat, busy_ok);

        // Back-to-back issue: a Start held during FINISH is accepted.
        @(negedge Clk);
        Start = 1'b1; OP = 4'h0; InputA = 8'h10; InputB = 8'h22;
        model_apply(4'h0, 8'h10, 8'h22, 3'd0, exp_lat);
        @(negedge Clk);
        check("b2b first done", 64'(Done), 64'(1));
        check("b2b first out",  64'(Out),  64'(8'h32));
        OP = 4'h2; InputA = 8'h02; InputB = 8'h10;
        model_apply(4'h2, 8'h02, 8'h10, 3'd0, exp_lat);
        @(negedge Clk);
        Start = 1'b0;
        check("b2b second done", 64'(Done),     64'(1));
        check("b2b second out",  64'(Out),      64'(8'h0E));
        check("b2b second c",    64'(CarryOut), 64'(0));

        // Random operations against the reference model.
        for (int i = 0; i < 200; i++) begin
            string tag;
            rop = 4'($urandom);
            ra  = W'($urandom);
            rb  = W'($urandom);
            rsh = SHW'($urandom);
            tag = $sformatf("rnd%0d op%0h", i, rop);
            model_apply(rop, ra, rb, rsh, exp_lat);
            run_op(tag, rop, ra, rb, rsh, 1'b1, lat, busy_ok);
            check_model(tag, lat, exp_lat, busy_ok);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
